prescaled_counter_bank: RTL

PRESCALED_COUNTER_BANK -- requirements
Module: prescaled_counter_bank

---
 rtl/prescaled_counter_bank.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/prescaled_counter_bank.sv
// prescaled_counter_bank
//
// A bank of NCH = 2**SEL_W independent event counters. Each channel has a
// programmable prescaler: a channel advances its counter once for every
// (div + 1) qualifying events. At all-ones, a channel either wraps to zero
// (SAT = 0) or holds at all-ones (SAT = 1). In both cases it raises a one-cycle
// terminal-count pulse and a sticky overflow flag.
//
// Ports
//   Clk      in   1          rising-edge clock
//   Reset    in   1          synchronous, active-high reset
//   En       in   1          one count event for channel Sel this cycle
//   Sel      in   SEL_W      channel receiving the En event
//   Clr      in   NCH        per-channel synchronous clear (bit i = channel i)
//   Cfg_we   in   1          divisor write strobe
//   Cfg_ch   in   SEL_W      channel targeted by the divisor write
//   Cfg_div  in   PRE_W      divisor value to load
//   Count    out  NCH*WIDTH  channel i counter on [i*WIDTH +: WIDTH]
//   Tc       out  NCH        per-channel terminal-count pulse
//   Ovf      out  NCH        per-channel sticky overflow flag
//
// All outputs come straight from flops.

module prescaled_counter_bank #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned SEL_W   = 1,
    parameter int unsigned PRE_W   = 4,
    parameter int unsigned DEF_DIV = 0,
    parameter bit          SAT     = 1'b0
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          En,
    input  logic [SEL_W-1:0]              Sel,
    input  logic [(2**SEL_W)-1:0]         Clr,
    input  logic                          Cfg_we,
    input  logic [SEL_W-1:0]              Cfg_ch,
    input  logic [PRE_W-1:0]              Cfg_div,
    output logic [(2**SEL_W)*WIDTH-1:0]   Count,
    output logic [(2**SEL_W)-1:0]         Tc,
    output logic [(2**SEL_W)-1:0]         Ovf
);

    localparam int NCH = 2 ** SEL_W;
    localparam logic [PRE_W-1:0] DefDiv = PRE_W'(DEF_DIV);

    logic [WIDTH-1:0] cnt_q [NCH];
    logic [WIDTH-1:0] cnt_d [NCH];
    logic [PRE_W-1:0] pre_q [NCH];
    logic [PRE_W-1:0] pre_d [NCH];
    logic [PRE_W-1:0] div_q [NCH];
    logic [PRE_W-1:0] div_d [NCH];
    logic [NCH-1:0]   tc_q;
    logic [NCH-1:0]   tc_d;
    logic [NCH-1:0]   ovf_q;
    logic [NCH-1:0]   ovf_d;

    // Per-channel decode of the shared event and config strobes.
    logic [NCH-1:0] hit;
    logic [NCH-1:0] wr;

    always_comb begin
        hit = '0;
        wr  = '0;
        for (int i = 0; i < NCH; i++) begin
            hit[i] = En && (Sel == SEL_W'(i));
            wr[i]  = Cfg_we && (Cfg_ch == SEL_W'(i));
        end
    end

    // Next-state logic. Priority per channel: clear, then divisor write, then
    // the count event. A clear and a divisor write on the same channel
    // both take effect: the divisor path is independent of the clear.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            pre_d[i] = pre_q[i];
            div_d[i] = div_q[i];
            tc_d[i]  = 1'b0;
            ovf_d[i] = ovf_q[i];

            if (wr[i]) begin
                div_d[i] = Cfg_div;
            end

            if (Clr[i]) begin
                cnt_d[i] = '0;
                pre_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (wr[i]) begin
                // A new divisor restarts the prescale phase; the same-cycle
                // event is dropped so it cannot be counted against the old ratio.
                pre_d[i] = '0;
            end else if (hit[i]) begin
                if (pre_q[i] == div_q[i]) begin
                    pre_d[i] = '0;
                    if (&cnt_q[i]) begin
                        tc_d[i]  = 1'b1;
                        ovf_d[i] = 1'b1;
                        cnt_d[i] = SAT ? cnt_q[i] : '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + WIDTH'(1);
                    end
                end else begin
                    pre_d[i] = pre_q[i] + PRE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
                pre_q[i] <= '0;
                div_q[i] <= DefDiv;
            end
            tc_q  <= '0;
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
                pre_q[i] <= pre_d[i];
                div_q[i] <= div_d[i];
            end
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        Count = '0;
        for (int i = 0; i < NCH; i++) begin
            Count[i*WIDTH +: WIDTH] = cnt_q[i];
        end
    end

    assign Tc  = tc_q;
    assign Ovf = ovf_q;

endmodule
